// File: rtl/spi_slave_top.sv
// SPI mode-0 slave: one address word then data words per SS-low frame, mapped onto read/write strobes.
// Optional macro ADDR_AUTOINC_EN steps the address per data word; without it every word targets the base address.
module spi_slave_top #(
    parameter int DWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              SS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DWIDTH-1:0] sig,
    output logic [DWIDTH-1:0] rd_addr,
    output logic              rd_req,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_en,
    output logic [CNTW-1:0]   word_cnt,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APHASE = 2'd1;
    localparam logic [1:0] DPHASE = 2'd2;

    localparam int BCW = $clog2(DWIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DWIDTH - 1);

    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [1:0]        state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DWIDTH-1:0] tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;
    logic [DWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [CNTW-1:0]   word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              ss_rise, ss_fall, sck_rise, sck_fall;
    logic [DWIDTH-1:0] rx_word;
    logic [DWIDTH-1:0] next_addr;

    // SS synchronizer resets low so a frame can only start after SS has been seen high.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_prev_q   <= 1'b0;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= SS;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sck_meta_q  <= SCK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign ss_rise  =  ss_sync_q  & ~ss_prev_q;
    assign ss_fall  = ~ss_sync_q  &  ss_prev_q;
    assign sck_rise =  sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q &  sck_prev_q;
    assign rx_word  = {rx_shift_q[DWIDTH-2:0], mosi_sync_q};

`ifdef ADDR_AUTOINC_EN
    assign next_addr = rd_addr_q + DWIDTH'(1);
`else
    assign next_addr = rd_addr_q;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        rd_addr_d    = rd_addr_q;
        rd_req_d     = 1'b0;
        rd_pend_d    = rd_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        word_cnt_d   = word_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        // rd_data is taken one cycle after the rd_req pulse; the MSB is then on MISO before the next word's first rise.
        if (rd_pend_q && state_q != IDLE) begin
            tx_shift_d = rd_data;
            miso_d     = rd_data[DWIDTH-1];
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    tx_shift_d = sig;
                    miso_d     = sig[DWIDTH-1];
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = APHASE;
                end
            end
            APHASE, DPHASE: begin
                if (sck_rise) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        rd_req_d  = 1'b1;
                        if (state_q == APHASE) begin
                            rd_addr_d = rx_word;
                            state_d   = DPHASE;
                        end else begin
                            wr_data_d  = rx_word;
                            wr_addr_d  = rd_addr_q;
                            wr_en_d    = 1'b1;
                            word_cnt_d = word_cnt_q + CNTW'(1);
                            rd_addr_d  = next_addr;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else if (sck_fall && bit_cnt_q != '0) begin
                    // The fall after a word's last rise keeps the freshly loaded MSB on MISO.
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[DWIDTH-2];
                end
                if (ss_rise) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    miso_d       = 1'b0;
                    bit_cnt_d    = '0;
                    frame_done_d = (word_cnt_d != '0);
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            rd_addr_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            rd_addr_q    <= rd_addr_d;
            rd_req_q     <= rd_req_d;
            rd_pend_q    <= rd_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            word_cnt_q   <= word_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign MISO       = miso_q;
    assign rd_addr    = rd_addr_q;
    assign rd_req     = rd_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign word_cnt   = word_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
